// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg -- shared constants for the UART transmitter.
//   DEF_CLK_DIV    : default clocks per serial bit (27 MHz / 115200).
//   DEF_FIFO_DEPTH : default transmit buffer depth in bytes (power of two, >= 2).
//   ST_*           : FSM state encoding.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_tx_pkg;
  localparam int DEF_CLK_DIV    = 234;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;
endpackage

// File: rtl/uart_tx_fifo.sv
// tx_fifo -- byte FIFO feeding the UART transmitter.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (discards contents)
//   push, din     : write strobe and byte; ignored while full
//   pop, dout     : read strobe and head byte (dout valid while !empty)
//   empty, full   : occupancy flags derived from the pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
import uart_tx_pkg::*;

module tx_fifo #(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr, count;
  logic        do_push, do_pop;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx -- buffered 8-bit UART transmitter (8N1, or 8E1 with parity).
// Ports:
//   clk   : sole clock
//   rst   : asynchronous active-high reset; aborts any frame, flushes FIFO
//   wr    : single-cycle write strobe, wdata sampled with it
//   full  : FIFO holds FIFO_DEPTH bytes
//   busy  : FIFO non-empty or a frame in progress
//   ovf   : one-cycle pulse after a write was dropped because full
//   tx    : registered serial line, idle high
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit.
import uart_tx_pkg::*;

module uart_tx #(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic       full,
  output logic       busy,
  output logic       ovf,
  output logic       tx
);
  localparam int             CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLK_DIV - 1);

  logic [2:0]    state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          baud_last, empty, pop;
  logic [7:0]    head;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .din   (wdata),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  assign baud_last = (baud == BAUD_LAST);
  // Load from IDLE, or straight out of the last stop cycle so that
  // back-to-back frames carry no idle gap.
  assign pop  = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_last));
  assign busy = ~empty | (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      baud <= ((state == ST_IDLE) || baud_last) ? '0 : baud + 1'b1;
      if (pop) begin
        shift <= head;
`ifdef UART_TX_PARITY_EN
        par   <= ^head;
`endif
      end
      case (state)
        ST_IDLE:  if (!empty) state <= ST_START;
        ST_START: if (baud_last) state <= ST_DATA;
        ST_DATA: begin
          if (baud_last) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;  // 3 bits: wraps 7 -> 0
`ifdef UART_TX_PARITY_EN
            if (bit_idx == 3'd7) state <= ST_PARITY;
`else
            if (bit_idx == 3'd7) state <= ST_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (baud_last) state <= ST_STOP;
`endif
        ST_STOP:  if (baud_last) state <= empty ? ST_IDLE : ST_START;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // tx is registered from the current state, so the line lags the FSM by
  // one clock; every bit still spans exactly CLK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx <= 1'b1;
    end else begin
      case (state)
        ST_START:  tx <= 1'b0;
        ST_DATA:   tx <= shift[0];
`ifdef UART_TX_PARITY_EN
        ST_PARITY: tx <= par;
`endif
        default:   tx <= 1'b1;
      endcase
    end
  end

  // Dropped-write flag: pop in the same cycle does not rescue the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else     ovf <= wr & full;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 234, SHALL set the clock cycles per serial bit (27 MHz / 115200).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the transmit buffer depth in bytes and SHALL be a power of two, minimum 2.
REQ-003 clk  in  1  SHALL be the only clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 wr  in  1  SHALL be the single-cycle write strobe from the memory block's I/O address decode.
REQ-006 wdata  in  8  SHALL carry the byte from the data bus, sampled when wr=1.
REQ-007 full  out  1  SHALL be high when the FIFO holds FIFO_DEPTH bytes.
REQ-008 busy  out  1  SHALL be high when the FIFO is non-empty or the FSM is not IDLE.
REQ-009 ovf  out  1  SHALL pulse high for one cycle when a write is dropped.
REQ-010 tx  out  1  SHALL be the serial line, idle high.

Function
REQ-011 The FIFO SHALL accept the write when wr=1 and full=0, and SHALL drop it with ovf=1 the next cycle when wr=1 and full=1, even if a pop occurs in the same cycle.
REQ-012 full and count SHALL come from registered read/write pointers that are one bit wider than log2(FIFO_DEPTH) and wrap modulo 2*FIFO_DEPTH.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, with the following behaviour:
  - IDLE with the FIFO non-empty: pop the head into a shift register and go to START.
  - START and STOP each last exactly CLK_DIV cycles.
  - DATA lasts 8*CLK_DIV cycles and sends the byte LSB first.
REQ-014 Transitions SHALL be:
  - START -> DATA.
  - DATA -> PARITY if enabled, otherwise DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> START directly if the FIFO is non-empty, popping at that edge with no extra idle cycle; otherwise STOP -> IDLE.
REQ-015 tx SHALL follow the state:
  - tx=1 in IDLE and STOP.
  - tx=0 in START.
  - tx=shift[0] in DATA.
  - tx=parity bit in PARITY.
  - tx SHALL be registered and glitch-free.
REQ-016 Latency: a write at edge N into an empty FIFO with the FSM in IDLE SHALL drive tx low after edge N+2.
REQ-017 The baud counter SHALL count 0..CLK_DIV-1 and then wrap, and the bit index SHALL count 0..7.
REQ-018 A pop and an accepted write in the same cycle SHALL leave the count unchanged.

Reset
REQ-019 Asserting rst SHALL immediately force the following, mid-frame included:
  - tx=1, full=0, busy=0, ovf=0.
  - FSM to IDLE.
  - Pointers, baud counter and bit index to 0.
REQ-020 A frame interrupted by reset SHALL NOT resume, and FIFO contents SHALL be discarded.

Configuration
REQ-021 With UART_TX_PARITY_EN defined, the PARITY state SHALL be included and SHALL transmit even parity, the XOR of the 8 data bits, for CLK_DIV cycles.
REQ-022 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and the frame SHALL be 10 bits, 8N1.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding constants and the default CLK_DIV/FIFO_DEPTH values.
REQ-024 The buffer SHALL be one sub-module, tx_fifo, with ports clk, rst, push, din, pop, dout, empty, full.
REQ-025 The FSM, baud counter and shifter SHALL reside in uart_tx.

Verification
REQ-026 The bench SHALL cover these directed scenarios, all with CLK_DIV=4:
  - Single byte: write 0x55 at edge N.
    -> tx low after N+2.
    -> Bits 1,0,1,0,1,0,1,0, each 4 cycles, then stop high.
    -> busy low after the stop bit.
  - Back-to-back: write 0xA3 then 0x0F on consecutive cycles.
    -> Two frames with no idle gap between the stop bit and the next start bit.
  - Overflow: 6 writes 0x01..0x06 in consecutive cycles, FIFO_DEPTH=4.
    -> full rises after the 5th accepted-state point.
    -> ovf pulses for each dropped byte.
    -> Transmitted sequence is exactly 0x01..0x05 (first byte popped before 6th write).
  - Reset mid-frame: assert rst during DATA bit 3 of 0xFF.
    -> tx=1 and busy=0 immediately.
    -> No frame after release until a new write.
  - Parity (UART_TX_PARITY_EN): write 0x07.
    -> Parity bit 1, frame length 11 bits = 44 cycles.
    -> Write 0x03 -> parity bit 0.
